// File: rtl/meter_pkg.sv
// Shared widths and the sample-to-level mapping for the four-channel audio level meter.
package meter_pkg;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned LEVEL_W  = 4;
  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned HOLD_W   = 6;

  typedef logic [LEVEL_W-1:0]  level_t;
  typedef logic [SAMPLE_W-1:0] sample_t;

  // Saturating absolute value (-128 clamps to 127), then the top four magnitude bits.
  function automatic level_t mag_to_level(input sample_t s);
    sample_t mag;
    mag = s[SAMPLE_W-1] ? (~s + sample_t'(1)) : s;
    if (mag[SAMPLE_W-1]) begin
      mag = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
    return mag[SAMPLE_W-2 -: LEVEL_W];
  endfunction

endpackage

// File: rtl/meter_channel.sv
// One meter channel: window peak capture, optional peak-hold counter and decaying level register.
// Hold counter exists only when CHANNEL_METER_PEAK_HOLD_EN is defined.
module meter_channel
  import meter_pkg::*;
`ifdef CHANNEL_METER_PEAK_HOLD_EN
#(
  parameter int unsigned HOLD_FRAMES = 30
)
`endif
(
  input  logic   clock,
  input  logic   reset_n,
  input  logic   ena,
  input  logic   tick,
  input  logic   decay_strobe,
  input  logic   hit,
  input  level_t hit_level,
  output level_t level
);

  level_t peak_q;
  level_t level_q;
  logic   hold_zero;
  logic   new_max;

  assign new_max = (peak_q >= level_q);

`ifdef CHANNEL_METER_PEAK_HOLD_EN
  logic [HOLD_W-1:0] hold_q;

  assign hold_zero = (hold_q == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else if (ena && tick) begin
      if (new_max) begin
        hold_q <= HOLD_W'(HOLD_FRAMES);
      end else if (!hold_zero) begin
        hold_q <= hold_q - HOLD_W'(1);
      end
    end
  end
`else
  assign hold_zero = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      peak_q  <= '0;
      level_q <= '0;
    end else if (ena) begin
      if (tick) begin
        // A sample landing on the tick opens the next window rather than joining the old one.
        peak_q <= hit ? hit_level : '0;
        if (new_max) begin
          level_q <= peak_q;
        end else if (hold_zero && decay_strobe) begin
          level_q <= level_q - LEVEL_W'(1);
        end
      end else if (hit && (hit_level > peak_q)) begin
        peak_q <= hit_level;
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/channel_meter.sv
// Four-channel audio level meter: per-frame peak capture with peak-hold and linear decay.
// Optional feature macro: CHANNEL_METER_PEAK_HOLD_EN (enables hold counters and HOLD_FRAMES).
module channel_meter
  import meter_pkg::*;
#(
`ifdef CHANNEL_METER_PEAK_HOLD_EN
  parameter int unsigned HOLD_FRAMES  = 30,
`endif
  parameter int unsigned DECAY_FRAMES = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ena,
  input  logic       vsync,
  input  logic       sample_valid,
  input  logic [1:0] sample_ch,
  input  logic [7:0] sample,
  output logic [3:0] s1,
  output logic [3:0] s2,
  output logic [3:0] s3,
  output logic [3:0] s4
);

  logic              vsync_q;
  logic              tick;
  logic              decay_strobe;
  logic [3:0]        decay_cnt_q;
  level_t            hit_level;
  logic [NUM_CH-1:0] hit;
  level_t            level [NUM_CH];

  // Frame tick on the vsync falling edge; vsync_q resets high so a high vsync at release is quiet.
  assign tick         = ena & vsync_q & ~vsync;
  assign decay_strobe = tick & (decay_cnt_q == 4'(DECAY_FRAMES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q     <= 1'b1;
      decay_cnt_q <= '0;
    end else if (ena) begin
      vsync_q <= vsync;
      if (tick) begin
        decay_cnt_q <= decay_strobe ? '0 : decay_cnt_q + 4'd1;
      end
    end
  end

  assign hit_level = mag_to_level(sample);

  always_comb begin
    hit            = '0;
    hit[sample_ch] = sample_valid;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    meter_channel
`ifdef CHANNEL_METER_PEAK_HOLD_EN
    #(
      .HOLD_FRAMES(HOLD_FRAMES)
    )
`endif
    u_ch (
      .clock       (clock),
      .reset_n     (reset_n),
      .ena         (ena),
      .tick        (tick),
      .decay_strobe(decay_strobe),
      .hit         (hit[i]),
      .hit_level   (hit_level),
      .level       (level[i])
    );
  end

  assign s1 = level[0];
  assign s2 = level[1];
  assign s3 = level[2];
  assign s4 = level[3];

endmodule

// File: tb/tb_channel_meter.sv
// Self-checking bench for channel_meter: directed scenarios plus randomized frames against a
// frame-level reference model.
module tb_channel_meter;

`ifdef CHANNEL_METER_PEAK_HOLD_EN
  localparam int HOLD  = 2;
  localparam int DECAY = 1;
`else
  localparam int HOLD  = 0;
  localparam int DECAY = 2;
`endif

  logic       clock;
  logic       reset_n;
  logic       ena;
  logic       vsync;
  logic       sample_valid;
  logic [1:0] sample_ch;
  logic [7:0] sample;
  logic [3:0] s1, s2, s3, s4;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_lvl[4];
  int m_peak[4];
  int m_hold[4];
  int m_cnt;
  bit m_vq;

  channel_meter #(
`ifdef CHANNEL_METER_PEAK_HOLD_EN
    .HOLD_FRAMES (HOLD),
`endif
    .DECAY_FRAMES(DECAY)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ena         (ena),
    .vsync       (vsync),
    .sample_valid(sample_valid),
    .sample_ch   (sample_ch),
    .sample      (sample),
    .s1          (s1),
    .s2          (s2),
    .s3          (s3),
    .s4          (s4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int ref_level(input logic [7:0] s);
    int v;
    v = $signed(s);
    if (v < 0) v = -v;
    if (v > 127) v = 127;
    return v / 8;
  endfunction

  function automatic logic [3:0] dut_level(input int c);
    case (c)
      0:       return s1;
      1:       return s2;
      2:       return s3;
      default: return s4;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_lvl[c]  = 0;
      m_peak[c] = 0;
      m_hold[c] = 0;
    end
    m_cnt = 0;
    m_vq  = 1'b1;
  endtask

  // Drive one cycle of inputs, advance the model by the same clock, then sample after the edge.
  task automatic cycle(input bit e, input bit vs, input bit v, input int ch, input int smp);
    bit tk;
    bit strobe;
    int hl;
    ena          = e;
    vsync        = vs;
    sample_valid = v;
    sample_ch    = ch[1:0];
    sample       = smp[7:0];
    if (e) begin
      tk   = m_vq && !vs;
      m_vq = vs;
      hl   = ref_level(smp[7:0]);
      if (tk) begin
        strobe = (m_cnt == DECAY - 1);
        m_cnt  = strobe ? 0 : m_cnt + 1;
        for (int c = 0; c < 4; c++) begin
          if (m_peak[c] >= m_lvl[c]) begin
            m_lvl[c]  = m_peak[c];
            m_hold[c] = HOLD;
          end else if (m_hold[c] != 0) begin
            m_hold[c] = m_hold[c] - 1;
          end else if (strobe) begin
            m_lvl[c] = m_lvl[c] - 1;
          end
          m_peak[c] = 0;
        end
        if (v) m_peak[ch] = hl;
      end else if (v && hl > m_peak[ch]) begin
        m_peak[ch] = hl;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic frame_silent(input int len);
    for (int i = 0; i < len; i++) cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    ena          = 1'b1;
    vsync        = 1'b1;
    sample_valid = 1'b0;
    sample_ch    = 2'd0;
    sample       = 8'd0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (dut_level(c) !== 4'd0) begin
        errors++;
        $display("FAIL reset_value ch%0d got %0d want 0", c, dut_level(c));
      end
    end
    for (int c = 0; c < 4; c++) cycle(1, 1, 1, c, 100);
    frame_silent(2);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (dut_level(c) !== 4'd12) begin
        errors++;
        $display("FAIL pre_reset_level ch%0d got %0d want 12", c, dut_level(c));
      end
    end
    // Partial window that reset must discard
    for (int c = 0; c < 4; c++) cycle(1, 1, 1, c, 120);
    #2 reset_n = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (dut_level(c) !== 4'd0) begin
        errors++;
        $display("FAIL async_reset ch%0d got %0d want 0", c, dut_level(c));
      end
    end
    model_reset();
    vsync = 1'b0;
    sample_valid = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
    frame_silent(4);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (dut_level(c) !== 4'd0) begin
        errors++;
        $display("FAIL post_release ch%0d got %0d want 0", c, dut_level(c));
      end
    end
  endtask

  task automatic test_saturation();
    logic [3:0] want[4];
    want = '{4'd15, 4'd15, 4'd1, 4'd0};
    do_reset();
    cycle(1, 1, 1, 0, 8'h80);
    cycle(1, 1, 1, 1, 8'h7F);
    cycle(1, 1, 1, 2, 8'hF8);
    checks++;
    if (s1 !== 4'd0) begin
      errors++;
      $display("FAIL sat_before_tick s1 got %0d want 0", s1);
    end
    frame_silent(2);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (dut_level(c) !== want[c]) begin
        errors++;
        $display("FAIL saturation ch%0d got %0d want %0d", c, dut_level(c), want[c]);
      end
    end
  endtask

  task automatic test_window_max();
    do_reset();
    cycle(1, 1, 1, 1, 40);
    cycle(1, 1, 1, 1, -72);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 1, 1, 16);
    checks++;
    if (s2 !== 4'd0) begin
      errors++;
      $display("FAIL window_mid_frame s2 got %0d want 0", s2);
    end
    frame_silent(1);
    checks++;
    if (s2 !== 4'd9) begin
      errors++;
      $display("FAIL window_max s2 got %0d want 9", s2);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1, 1, 1, 1, 20);
      checks++;
      if (s2 !== 4'd9) begin
        errors++;
        $display("FAIL window_steady s2 got %0d want 9", s2);
      end
    end
  endtask

`ifdef CHANNEL_METER_PEAK_HOLD_EN
  task automatic test_hold_decay();
    int want;
    do_reset();
    cycle(1, 1, 1, 0, 100);
    for (int k = 1; k <= 18; k++) begin
      frame_silent(3);
      want = (k <= 3) ? 12 : ((12 - (k - 3)) > 0 ? 12 - (k - 3) : 0);
      checks++;
      if (s1 !== want[3:0]) begin
        errors++;
        $display("FAIL hold_decay tick%0d s1 got %0d want %0d", k, s1, want);
      end
    end
  endtask
`else
  task automatic test_decay_nohold();
    int want;
    do_reset();
    cycle(1, 1, 1, 0, 64);
    for (int k = 1; k <= 20; k++) begin
      frame_silent(3);
      want = (8 - k / 2) > 0 ? 8 - k / 2 : 0;
      checks++;
      if (s1 !== want[3:0]) begin
        errors++;
        $display("FAIL decay_nohold tick%0d s1 got %0d want %0d", k, s1, want);
      end
    end
  endtask
`endif

  task automatic test_coincident_and_ena();
    do_reset();
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 1, 2, 127);
    checks++;
    if (s3 !== 4'd0) begin
      errors++;
      $display("FAIL coincident_same_tick s3 got %0d want 0", s3);
    end
    frame_silent(3);
    checks++;
    if (s3 !== 4'd15) begin
      errors++;
      $display("FAIL coincident_next_tick s3 got %0d want 15", s3);
    end
    // vsync falls and recovers entirely while ena is low; samples in that span are ignored
    cycle(1, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 127);
    cycle(0, 0, 1, 0, 127);
    cycle(0, 0, 1, 1, -128);
    cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    checks++;
    if (s3 !== 4'd15 || s1 !== 4'd0) begin
      errors++;
      $display("FAIL ena_gating s1/s3 got %0d/%0d want 0/15", s1, s3);
    end
    frame_silent(2);
    checks++;
    if (s1 !== 4'd0 || s2 !== 4'd0) begin
      errors++;
      $display("FAIL ena_sample_ignored s1/s2 got %0d/%0d want 0/0", s1, s2);
    end
    checks++;
    if (s3 !== 4'(m_lvl[2])) begin
      errors++;
      $display("FAIL ena_after_tick s3 got %0d want %0d", s3, m_lvl[2]);
    end
  endtask

  task automatic test_random();
    int len;
    int dens;
    int low;
    do_reset();
    for (int f = 0; f < 30; f++) begin
      len  = $urandom_range(10, 50);
      dens = $urandom_range(0, 3);
      low  = $urandom_range(1, 4);
      for (int i = 0; i < len + low; i++) begin
        cycle(($urandom_range(0, 9) != 0), (i < len),
              (dens != 0) && ($urandom_range(0, 3) < dens),
              $urandom_range(0, 3), $urandom_range(0, 255));
        for (int c = 0; c < 4; c++) begin
          checks++;
          if (dut_level(c) !== 4'(m_lvl[c])) begin
            errors++;
            $display("FAIL random f%0d cyc%0d ch%0d got %0d want %0d",
                     f, i, c, dut_level(c), m_lvl[c]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_window_max();
`ifdef CHANNEL_METER_PEAK_HOLD_EN
    test_hold_decay();
`else
    test_decay_nohold();
`endif
    test_coincident_and_ena();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
